// File: rtl/msg_arbiter.sv
// msg_arbiter: message-granular round-robin arbiter in front of a head/data/tail channel.
// Define MSG_ARB_TIMEOUT_EN to build the owner-stall counter and the abort pulse.
module msg_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int IDX_W    = 2,
  parameter int DATA_W   = 8,
  parameter int MAX_IDLE = 15
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_head,
  input  logic [NUM_REQ-1:0]        req_tail,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic                      out_head,
  output logic                      out_tail,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      msg_ip,
  output logic                      abort
);

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_BUSY = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] last_owner;
  logic             started;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] scan_idx;
  logic             win_found;
  logic             accept;

  if (NUM_REQ < 2 || NUM_REQ > 8 || (2 ** IDX_W) < NUM_REQ || MAX_IDLE < 1) begin : g_param_check
    $error("msg_arbiter: illegal NUM_REQ/IDX_W/MAX_IDLE combination");
  end

  // Round-robin search starting just past the previous owner; first eligible head wins.
  always_comb begin
    winner    = last_owner;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = IDX_W'((int'(last_owner) + k) % NUM_REQ);
      if (!win_found && req_valid[scan_idx] && req_head[scan_idx]) begin
        winner    = scan_idx;
        win_found = 1'b1;
      end
    end
  end

  // The abort cycle suppresses handshakes so no beat is half-accepted as the owner is dropped.
  always_comb begin
    out_valid = 1'b0;
    out_head  = 1'b0;
    out_tail  = 1'b0;
    out_data  = '0;
    req_ready = '0;
    if (state == ARB_BUSY) begin
      out_valid        = req_valid[owner] & ~abort;
      out_head         = req_head[owner];
      out_tail         = req_tail[owner];
      out_data         = req_data[owner*DATA_W +: DATA_W];
      req_ready[owner] = out_ready & ~abort;
    end
  end

  assign accept = out_valid & out_ready;

`ifdef MSG_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_IDLE + 1);

  logic [CNT_W-1:0] stall_cnt;

  // Only owner-side stalls count; downstream backpressure never ages the grant.
  always_ff @(posedge clock) begin
    if (reset || state == ARB_IDLE || accept) begin
      stall_cnt <= '0;
    end else if (!req_valid[owner] && stall_cnt != CNT_W'(MAX_IDLE)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign abort = (state == ARB_BUSY) && (stall_cnt == CNT_W'(MAX_IDLE));
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ARB_IDLE;
      owner      <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
      grant      <= '0;
      msg_ip     <= 1'b0;
      started    <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (win_found) begin
            state <= ARB_BUSY;
            owner <= winner;
            grant <= NUM_REQ'(1) << winner;
          end
        end
        default: begin
          if (abort || (accept && out_tail)) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            msg_ip     <= 1'b0;
            started    <= 1'b0;
            last_owner <= owner;
          end else if (accept && out_head && !started) begin
            started <= 1'b1;
            msg_ip  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
